// File: rtl/tcb_arbiter.sv
// tcb_arbiter: round-robin arbiter sharing one fixed-delay TCB subordinate among MN managers,
// with grant lock through stalls and index tracking to route delayed responses.
module tcb_arbiter #(
    parameter int MN  = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int DLY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MN-1:0]          sub_vld,
    input  logic [MN-1:0]          sub_wen,
    input  logic [MN-1:0][AW-1:0]  sub_adr,
    input  logic [MN-1:0][DW-1:0]  sub_wdt,
    output logic [MN-1:0]          sub_rdy,
    output logic [MN-1:0][DW-1:0]  sub_rdt,
    output logic [MN-1:0]          sub_err,
    output logic                   man_vld,
    output logic                   man_wen,
    output logic [AW-1:0]          man_adr,
    output logic [DW-1:0]          man_wdt,
    input  logic                   man_rdy,
    input  logic [DW-1:0]          man_rdt,
    input  logic                   man_err
);
    localparam int IW = $clog2(MN);

    if (MN < 2 || DLY < 1) begin : g_chk
        $error("tcb_arbiter: MN must be >= 2 and DLY >= 1");
    end

    typedef enum logic {ARB, LOCK} state_t;

    state_t                     state, state_nxt;
    logic [IW-1:0]              ptr, lck, gnt_idx;
    logic [MN-1:0]              gnt;
    logic                       locked, found, xfer;
    logic [DLY-1:0]             trk_vld;
    logic [DLY-1:0][IW-1:0]     trk_idx;

    // The lock only holds while its manager keeps requesting; a dropped vld falls back to arbitration.
    assign locked  = (state == LOCK) && sub_vld[lck];
    assign man_vld = |sub_vld;
    assign xfer    = man_vld & man_rdy;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < MN; k++) begin
            if (!found && sub_vld[(int'(ptr) + k) % MN]) begin
                gnt_idx = IW'((int'(ptr) + k) % MN);
                found   = 1'b1;
            end
        end
        if (locked) gnt_idx = lck;
    end

    assign gnt     = man_vld ? ({{(MN-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign sub_rdy = {MN{man_rdy}} & gnt;
    assign man_wen = man_vld & sub_wen[gnt_idx];
    assign man_adr = man_vld ? sub_adr[gnt_idx] : '0;
    assign man_wdt = man_vld ? sub_wdt[gnt_idx] : '0;

    always_comb begin
        state_nxt = state;
        state_nxt = (man_vld && !man_rdy) ? LOCK : ARB;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB;
            ptr     <= '0;
            lck     <= '0;
            trk_vld <= '0;
            trk_idx <= '0;
        end else begin
            state <= state_nxt;
            if (man_vld && !man_rdy) lck <= gnt_idx;
            if (xfer) ptr <= (int'(gnt_idx) == MN-1) ? '0 : gnt_idx + 1'b1;
            trk_vld[0] <= xfer;
            trk_idx[0] <= gnt_idx;
            for (int s = DLY-1; s > 0; s--) begin
                trk_vld[s] <= trk_vld[s-1];
                trk_idx[s] <= trk_idx[s-1];
            end
        end
    end

    always_comb begin
        sub_rdt = '0;
        sub_err = '0;
        for (int i = 0; i < MN; i++) begin
            if (trk_vld[DLY-1] && trk_idx[DLY-1] == IW'(i)) begin
                sub_rdt[i] = man_rdt;
                sub_err[i] = man_err;
            end
        end
    end
endmodule

// File: tb/tb_tcb_arbiter.sv
// tb_tcb_arbiter: directed vectors for tcb_arbiter; one instance with DLY=1 and one with DLY=2
// share the same stimulus so arbitration matches and only response timing differs.
module tb_tcb_arbiter;
    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        sub_vld, sub_wen;
    logic [1:0][31:0]  sub_adr, sub_wdt;
    logic              man_rdy, man_err;
    logic [31:0]       man_rdt;

    logic [1:0]        r1_rdy, r1_err, r2_rdy, r2_err;
    logic [1:0][31:0]  r1_rdt, r2_rdt;
    logic              m1_vld, m1_wen, m2_vld, m2_wen;
    logic [31:0]       m1_adr, m1_wdt, m2_adr, m2_wdt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    tcb_arbiter #(.MN(2), .AW(32), .DW(32), .DLY(1)) u1 (
        .clk(clk), .rst(rst),
        .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_wdt(sub_wdt),
        .sub_rdy(r1_rdy), .sub_rdt(r1_rdt), .sub_err(r1_err),
        .man_vld(m1_vld), .man_wen(m1_wen), .man_adr(m1_adr), .man_wdt(m1_wdt),
        .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err)
    );

    tcb_arbiter #(.MN(2), .AW(32), .DW(32), .DLY(2)) u2 (
        .clk(clk), .rst(rst),
        .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_wdt(sub_wdt),
        .sub_rdy(r2_rdy), .sub_rdt(r2_rdt), .sub_err(r2_err),
        .man_vld(m2_vld), .man_wen(m2_wen), .man_adr(m2_adr), .man_wdt(m2_wdt),
        .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sub_vld = 2'b11; sub_wen = 2'b00; man_rdy = 1'b1;
        sub_adr[0] = 32'h100; sub_adr[1] = 32'h200;
        sub_wdt = '0; man_rdt = 32'h5A; man_err = 1'b1;
        step(); #1;
        chk("rst_rdy", r1_rdy, 2'b01);
        chk("rst_rdt", r1_rdt, 0);
        chk("rst_err", r1_err, 0);
        chk("rst_rdt2", r2_rdt, 0);

        step(); rst = 1'b0; sub_vld = 2'b00; man_rdt = '0; man_err = 1'b0; #1;
        chk("idle_vld", m1_vld, 0);
        chk("idle_adr", m1_adr, 0);

        // single read from manager 1
        step(); sub_vld = 2'b10; sub_adr[1] = 32'h8; #1;
        chk("single_adr", m1_adr, 32'h8);
        chk("single_rdy", r1_rdy, 2'b10);
        step(); sub_vld = 2'b00; man_rdt = 32'hA5; #1;
        chk("single_rdt1", r1_rdt[1], 32'hA5);
        chk("single_rdt0", r1_rdt[0], 0);
        sub_adr[1] = 32'h200;

        // round robin with writes, ptr back at 0
        step(); man_rdt = '0; sub_vld = 2'b11; sub_wen = 2'b11;
        sub_wdt[0] = 32'hD0; sub_wdt[1] = 32'hD1;
        for (int n = 0; n < 4; n++) begin
            if (n > 0) step();
            #1;
            chk("rr_adr", m1_adr, (n % 2) ? 32'h200 : 32'h100);
            chk("rr_rdy", r1_rdy, (n % 2) ? 2'b10 : 2'b01);
            chk("rr_wdt", m1_wdt, (n % 2) ? 32'hD1 : 32'hD0);
            chk("rr_wen", m1_wen, 1);
        end
        sub_wen = 2'b00;

        // stall: manager 1 locked while manager 0 (higher priority) asserts
        step(); sub_vld = 2'b10; man_rdy = 1'b0; #1;
        chk("stall_adr0", m1_adr, 32'h200);
        chk("stall_rdy0", r1_rdy, 2'b00);
        for (int n = 0; n < 2; n++) begin
            step(); sub_vld = 2'b11; #1;
            chk("stall_adr", m1_adr, 32'h200);
            chk("stall_rdy", r1_rdy, 2'b00);
        end
        step(); man_rdy = 1'b1; #1;
        chk("stall_xfer", r1_rdy, 2'b10);
        step(); #1;
        chk("stall_next_rdy", r1_rdy, 2'b01);
        chk("stall_next_adr", m1_adr, 32'h100);

        // pipelined routing on the DLY=2 instance: grants 0,1,0
        step(); sub_vld = 2'b01; #1;
        chk("pipe_g0", r2_rdy, 2'b01);
        step(); sub_vld = 2'b11; #1;
        chk("pipe_g1", r2_rdy, 2'b10);
        step(); man_rdt = 32'h11; #1;
        chk("pipe_g2", r2_rdy, 2'b01);
        chk("pipe_r0", r2_rdt[0], 32'h11);
        chk("pipe_r0x", r2_rdt[1], 0);
        step(); sub_vld = 2'b00; man_rdt = 32'h22; #1;
        chk("pipe_r1", r2_rdt[1], 32'h22);
        chk("pipe_r1x", r2_rdt[0], 0);
        step(); man_rdt = 32'h33; #1;
        chk("pipe_r2", r2_rdt[0], 32'h33);
        chk("pipe_r2x", r2_rdt[1], 0);

        // error routing from manager 1
        step(); man_rdt = '0; sub_vld = 2'b10; #1;
        chk("err_xfer", r1_rdy, 2'b10);
        step(); sub_vld = 2'b00; man_err = 1'b1; #1;
        chk("err_d1", r1_err, 2'b10);
        chk("err_d2_early", r2_err, 2'b00);
        step(); #1;
        chk("err_d1_after", r1_err, 2'b00);
        chk("err_d2", r2_err, 2'b10);
        step(); man_err = 1'b0;

        // reset between transfer and response
        sub_vld = 2'b01; #1;
        chk("rstmid_xfer", r1_rdy, 2'b01);
        step(); sub_vld = 2'b11; rst = 1'b1; man_rdt = 32'h77; #1;
        chk("rstmid_rdt1", r1_rdt, 0);
        chk("rstmid_rdy", r1_rdy, 2'b01);
        step(); rst = 1'b0; #1;
        chk("rstmid_adr", m1_adr, 32'h100);
        chk("rstmid_rdt2", r2_rdt, 0);
        chk("rstmid_rdt1b", r1_rdt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/tcb_arbiter.md
# tcb_arbiter

Round-robin arbiter that shares one TCB subordinate, such as the GPIO controller, between MN TCB managers. It forwards the request of exactly one manager per cycle and holds that grant through subordinate stalls. It tracks in-flight transfers so that the read data and error response, which return DLY cycles later, reach the manager that issued the transfer. It sits between the CPU/debug/DMA managers and a peripheral with a fixed response delay.

## Interface
Parameters:
- MN, 2: number of managers; must be ≥2.
- AW, 32: address width.
- DW, 32: data width.
- DLY, 1: subordinate response delay in cycles; must be ≥1. Elaboration `$error` if MN<2 or DLY<1.
- IW, $clog2(MN): local; manager index width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- sub_vld  input  [MN-1:0]  per-manager request valid.
- sub_wen  input  [MN-1:0]  per-manager write enable.
- sub_adr  input  [MN-1:0][AW-1:0]  per-manager address.
- sub_wdt  input  [MN-1:0][DW-1:0]  per-manager write data.
- sub_rdy  output  [MN-1:0]  per-manager ready.
- sub_rdt  output  [MN-1:0][DW-1:0]  per-manager read data.
- sub_err  output  [MN-1:0]  per-manager error response.
- man_vld  output  1  request valid to the subordinate.
- man_wen  output  1  write enable to the subordinate.
- man_adr  output  AW  address to the subordinate.
- man_wdt  output  DW  write data to the subordinate.
- man_rdy  input  1  subordinate ready.
- man_rdt  input  DW  subordinate read data, valid DLY cycles after a transfer.
- man_err  input  1  subordinate error, valid DLY cycles after a transfer.

## Operation
- Transfer: a transfer happens in any cycle where man_vld & man_rdy is high.
- Manager obligation: a manager holds vld and its request fields stable until it sees its rdy.
- Priority pointer `ptr`: IW-bit register, reset 0. Manager `ptr` has the highest priority; priority then decreases with index modulo MN.
- Pointer update: after a transfer granted to manager i, `ptr` ← (i+1) mod MN. Wrap-around: from MN-1 it goes to 0.
- Grant selection: when not locked, the grant is the first requesting manager at or after `ptr`, searching modulo MN.
- Grant lock:
  - States: IDLE/ARB (unlocked) and LOCK.
  - ARB→LOCK when man_vld & ~man_rdy; the locked index is stored.
  - LOCK→ARB on the transfer of the locked manager.
  - In LOCK the grant stays on the locked manager regardless of other requests.
  - If the locked manager drops vld (a protocol violation), the block returns to ARB.
- Request path:
  - man_vld = |sub_vld.
  - man_wen/adr/wdt are muxed from the granted manager; they are '0 when no manager requests.
  - sub_rdy[i] = man_rdy & gnt[i].
- Response tracking: a DLY-stage shift register; each stage holds a valid bit and an IW-bit index.
  - Stage 0 loads (transfer, granted index).
  - Each stage advances every cycle.
- Response routing, from the last stage (valid, idx):
  - sub_rdt[idx] = man_rdt and sub_err[idx] = man_err.
  - All other managers, and every manager when the stage is not valid, see rdt='0 and err=0.
- Reset clears `ptr`, the lock, and all tracking stages.

## Timing
- Arbitration is combinational; a lone request to an idle arbiter with man_rdy=1 transfers in the same cycle.
- Back-to-back transfers from different managers in consecutive cycles are supported at full throughput.
- The response for the transfer in cycle t appears on sub_rdt/sub_err in cycle t+DLY, routed per the stored index.
- Simultaneous requests: exactly one grant per cycle. No manager waits more than MN-1 transfers once its request is asserted.
- Outputs while rst is asserted:
  - sub_rdy = man_rdy & gnt, with ptr=0 and the lock cleared.
  - sub_rdt='0 and sub_err='0 (tracking cleared).
  - man_* follow the combinational mux.
- Reset during an in-flight response: the response is dropped; nothing is routed afterwards.

## Test plan
- Single request: MN=2, DLY=1; manager 1 reads adr=0x8 with man_rdy=1, subordinate returns 0xA5 → man_adr=0x8 in cycle t; sub_rdt[1]=0xA5 in t+1; sub_rdt[0]=0.
- Round robin: both managers request continuously with man_rdy=1 → grants 0,1,0,1; ptr toggles every cycle.
- Stall lock: manager 1 granted with man_rdy=0 for 3 cycles while manager 0 asserts → man_adr stays on manager 1; sub_rdy[0]=0; manager 0 is granted on the cycle after manager 1's transfer.
- Pipelined routing: DLY=2, transfers from 0,1,0 in consecutive cycles, subordinate returns 0x11,0x22,0x33 → sub_rdt[0]=0x11, sub_rdt[1]=0x22, sub_rdt[0]=0x33 in t+2..t+4.
- Error routing: manager 1 transfer with man_err=1 in the response cycle → sub_err=2'b10 for that single cycle.
- Reset mid-operation: assert rst between a transfer and its response → no response delivered; ptr=0; the first grant after release goes to manager 0 when both request.
